// File: rtl/video_cfg_ctrl.sv
// video_cfg_ctrl: decodes the framed MCU byte stream, forwards OSD traffic and
// manages shadowed video configuration registers committed atomically on vsync.
module video_cfg_ctrl #(
  parameter logic [8:0] AUDIO_DIV_RESET = 9'd280,
  parameter bit         COMMIT_ON_VSYNC = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  output logic [7:0] mcu_dout,
  input  logic       vs_in_n,
  output logic       osd_start,
  output logic       osd_strobe,
  output logic [7:0] osd_data,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       ntscmode,
  output logic [8:0] audio_div,
  output logic       cfg_pending
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_OSD     = 3'd2,
    ST_WADDR   = 3'd3,
    ST_WDATA   = 3'd4,
    ST_RADDR   = 3'd5,
    ST_RDATA   = 3'd6,
    ST_DISCARD = 3'd7
  } state_t;

  state_t      state_r;
  logic [2:0]  ptr_r;
  logic        vs_prev_r;
  logic        wr_d_r;

  logic [1:0]  sh_scan_r;
  logic [1:0]  sh_vol_r;
  logic        sh_wide_r;
  logic        sh_ntsc_r;
  logic [8:0]  sh_adiv_r;

  logic        strobe_s;
  logic        wr_s;
  logic        commit_s;
  logic [2:0]  rd_addr_s;
  logic [7:0]  rd_byte_s;

  // A strobe coinciding with start is dropped; writes happen only in WDATA.
  always_comb begin
    strobe_s = mcu_strobe & ~mcu_start;
    wr_s     = strobe_s & (state_r == ST_WDATA);
  end

  // Commit event: vsync falling edge, or the cycle after a write in immediate mode.
  always_comb begin
    if (COMMIT_ON_VSYNC) begin
      commit_s = vs_prev_r & ~vs_in_n;
    end else begin
      commit_s = wr_d_r;
    end
  end

  // Read-back mux over the live registers; RADDR uses the incoming address, RDATA the next one.
  always_comb begin
    if (state_r == ST_RADDR) begin
      rd_addr_s = mcu_data[2:0];
    end else begin
      rd_addr_s = ptr_r + 3'd1;
    end
    case (rd_addr_s)
      3'd0:    rd_byte_s = {6'd0, system_scanlines};
      3'd1:    rd_byte_s = {6'd0, system_volume};
      3'd2:    rd_byte_s = {7'd0, system_wide_screen};
      3'd3:    rd_byte_s = {7'd0, ntscmode};
      3'd4:    rd_byte_s = audio_div[7:0];
      3'd5:    rd_byte_s = {7'd0, audio_div[8]};
      default: rd_byte_s = 8'd0;
    endcase
  end

  // Transaction FSM with registered OSD and read-back outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'd0;
      osd_start  <= 1'b0;
      osd_strobe <= 1'b0;
      osd_data   <= 8'd0;
      mcu_dout   <= 8'd0;
    end else begin
      osd_start  <= 1'b0;
      osd_strobe <= 1'b0;
      if (mcu_start) begin
        state_r <= ST_CMD;
      end else if (mcu_strobe) begin
        case (state_r)
          ST_CMD: begin
            case (mcu_data)
              8'h01: begin
                state_r   <= ST_OSD;
                osd_start <= 1'b1;
              end
              8'h02:   state_r <= ST_WADDR;
              8'h03:   state_r <= ST_RADDR;
              default: state_r <= ST_DISCARD;
            endcase
          end
          ST_OSD: begin
            osd_strobe <= 1'b1;
            osd_data   <= mcu_data;
          end
          ST_WADDR: begin
            ptr_r   <= mcu_data[2:0];
            state_r <= ST_WDATA;
          end
          ST_WDATA: begin
            ptr_r <= ptr_r + 3'd1;
          end
          ST_RADDR: begin
            ptr_r    <= mcu_data[2:0];
            mcu_dout <= rd_byte_s;
            state_r  <= ST_RDATA;
          end
          ST_RDATA: begin
            ptr_r    <= ptr_r + 3'd1;
            mcu_dout <= rd_byte_s;
          end
          default: state_r <= state_r;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Shadow register file; addresses 6 and 7 have no storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_scan_r <= 2'd0;
      sh_vol_r  <= 2'd3;
      sh_wide_r <= 1'b0;
      sh_ntsc_r <= 1'b0;
      sh_adiv_r <= AUDIO_DIV_RESET;
    end else if (wr_s) begin
      case (ptr_r)
        3'd0:    sh_scan_r      <= mcu_data[1:0];
        3'd1:    sh_vol_r       <= mcu_data[1:0];
        3'd2:    sh_wide_r      <= mcu_data[0];
        3'd3:    sh_ntsc_r      <= mcu_data[0];
        3'd4:    sh_adiv_r[7:0] <= mcu_data;
        3'd5:    sh_adiv_r[8]   <= mcu_data[0];
        default: sh_adiv_r      <= sh_adiv_r;
      endcase
    end
  end

  // Live registers load the whole pre-write shadow set at once; a same-cycle write keeps pending set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      system_scanlines   <= 2'd0;
      system_volume      <= 2'd3;
      system_wide_screen <= 1'b0;
      ntscmode           <= 1'b0;
      audio_div          <= AUDIO_DIV_RESET;
      cfg_pending        <= 1'b0;
    end else begin
      if (commit_s && cfg_pending) begin
        system_scanlines   <= sh_scan_r;
        system_volume      <= sh_vol_r;
        system_wide_screen <= sh_wide_r;
        ntscmode           <= sh_ntsc_r;
        audio_div          <= sh_adiv_r;
      end
      if (wr_s && (ptr_r <= 3'd5)) begin
        cfg_pending <= 1'b1;
      end else if (commit_s) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Edge-detect history for vsync and the delayed write flag for immediate commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_r <= 1'b1;
      wr_d_r    <= 1'b0;
    end else begin
      vs_prev_r <= vs_in_n;
      wr_d_r    <= wr_s;
    end
  end

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Directed self-checking bench for video_cfg_ctrl (vsync commit mode).
module tb_video_cfg_ctrl;

  logic       clk;
  logic       reset_n;
  logic       mcu_start;
  logic       mcu_strobe;
  logic [7:0] mcu_data;
  logic [7:0] mcu_dout;
  logic       vs_in_n;
  logic       osd_start;
  logic       osd_strobe;
  logic [7:0] osd_data;
  logic [1:0] system_scanlines;
  logic [1:0] system_volume;
  logic       system_wide_screen;
  logic       ntscmode;
  logic [8:0] audio_div;
  logic       cfg_pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  video_cfg_ctrl #(.AUDIO_DIV_RESET(9'd280), .COMMIT_ON_VSYNC(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mcu_start(mcu_start), .mcu_strobe(mcu_strobe),
    .mcu_data(mcu_data), .mcu_dout(mcu_dout), .vs_in_n(vs_in_n), .osd_start(osd_start),
    .osd_strobe(osd_strobe), .osd_data(osd_data), .system_scanlines(system_scanlines),
    .system_volume(system_volume), .system_wide_screen(system_wide_screen),
    .ntscmode(ntscmode), .audio_div(audio_div), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic s, input logic st, input logic [7:0] d);
    mcu_start  = s;
    mcu_strobe = st;
    mcu_data   = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    total_cnt++; if (system_volume !== 2'd3) $display("FAIL rst_volume: got %0d expected 3", system_volume); else pass_cnt++;
    total_cnt++; if (audio_div !== 9'd280) $display("FAIL rst_audio_div: got %0d expected 280", audio_div); else pass_cnt++;
    total_cnt++; if (system_scanlines !== 2'd0) $display("FAIL rst_scanlines: got %0d expected 0", system_scanlines); else pass_cnt++;
    total_cnt++; if (system_wide_screen !== 1'b0) $display("FAIL rst_wide: got %0d expected 0", system_wide_screen); else pass_cnt++;
    total_cnt++; if (ntscmode !== 1'b0) $display("FAIL rst_ntsc: got %0d expected 0", ntscmode); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b0) $display("FAIL rst_pending: got %0d expected 0", cfg_pending); else pass_cnt++;
    total_cnt++; if ({osd_start, osd_strobe, osd_data, mcu_dout} !== 18'd0) $display("FAIL rst_osd_dout: got %0h expected 0", {osd_start, osd_strobe, osd_data, mcu_dout}); else pass_cnt++;
  endtask

  task automatic test_osd;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    total_cnt++; if (osd_start !== 1'b1) $display("FAIL osd_start_pulse: got %0d expected 1", osd_start); else pass_cnt++;
    total_cnt++; if (osd_strobe !== 1'b0 || osd_data !== 8'h00) $display("FAIL osd_cmd_not_fwd: got strobe %0d data %0h expected 0 00", osd_strobe, osd_data); else pass_cnt++;
    step(1'b0, 1'b1, 8'hA5);
    total_cnt++; if (osd_start !== 1'b0) $display("FAIL osd_start_single: got %0d expected 0", osd_start); else pass_cnt++;
    total_cnt++; if (osd_strobe !== 1'b1 || osd_data !== 8'hA5) $display("FAIL osd_byte1: got strobe %0d data %0h expected 1 a5", osd_strobe, osd_data); else pass_cnt++;
    step(1'b0, 1'b1, 8'h3C);
    total_cnt++; if (osd_strobe !== 1'b1 || osd_data !== 8'h3C) $display("FAIL osd_byte2: got strobe %0d data %0h expected 1 3c", osd_strobe, osd_data); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (osd_strobe !== 1'b0) $display("FAIL osd_strobe_end: got %0d expected 0", osd_strobe); else pass_cnt++;
  endtask

  task automatic test_shadow_write;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h04);
    step(1'b0, 1'b1, 8'h2C);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (audio_div !== 9'd280) $display("FAIL sw_audio_held: got %0d expected 280", audio_div); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b1) $display("FAIL sw_pending_set: got %0d expected 1", cfg_pending); else pass_cnt++;
    vs_in_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (audio_div !== 9'd300) $display("FAIL sw_audio_commit: got %0d expected 300", audio_div); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b0) $display("FAIL sw_pending_clr: got %0d expected 0", cfg_pending); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00);
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_collision;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h01);
    total_cnt++; if (system_volume !== 2'd3) $display("FAIL col_vol_before: got %0d expected 3", system_volume); else pass_cnt++;
    vs_in_n = 1'b0;
    step(1'b0, 1'b1, 8'h01);
    total_cnt++; if (system_volume !== 2'd2) $display("FAIL col_vol_first: got %0d expected 2", system_volume); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b1) $display("FAIL col_pending_kept: got %0d expected 1", cfg_pending); else pass_cnt++;
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (system_volume !== 2'd2) $display("FAIL col_vol_hold: got %0d expected 2", system_volume); else pass_cnt++;
    vs_in_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (system_volume !== 2'd1) $display("FAIL col_vol_second: got %0d expected 1", system_volume); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b0) $display("FAIL col_pending_clr: got %0d expected 0", cfg_pending); else pass_cnt++;
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (system_volume !== 2'd3) $display("FAIL mrst_volume: got %0d expected 3", system_volume); else pass_cnt++;
    total_cnt++; if (audio_div !== 9'd280) $display("FAIL mrst_audio_div: got %0d expected 280", audio_div); else pass_cnt++;
    total_cnt++; if (cfg_pending !== 1'b0) $display("FAIL mrst_pending: got %0d expected 0", cfg_pending); else pass_cnt++;
    mcu_start = 1'b0; mcu_strobe = 1'b0; mcu_data = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    vs_in_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (system_scanlines !== 2'd0) $display("FAIL mrst_shadow_lost: got %0d expected 0", system_scanlines); else pass_cnt++;
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_read_wrap;
    logic [7:0] exp_rd [5] = '{8'h18, 8'h01, 8'h00, 8'h00, 8'h00};
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h01);
    vs_in_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (ntscmode !== 1'b1) $display("FAIL rd_ntsc_live: got %0d expected 1", ntscmode); else pass_cnt++;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h03);
    total_cnt++; if (mcu_dout !== 8'h01) $display("FAIL rd_addr3: got %0h expected 01", mcu_dout); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (mcu_dout !== 8'h01) $display("FAIL rd_hold: got %0h expected 01", mcu_dout); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'hFF);
      total_cnt++; if (mcu_dout !== exp_rd[i]) $display("FAIL rd_seq%0d: got %0h expected %0h", i, mcu_dout, exp_rd[i]); else pass_cnt++;
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_abort;
    logic saw_strobe;
    saw_strobe = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    saw_strobe = saw_strobe | osd_strobe;
    step(1'b0, 1'b1, 8'h7F);
    saw_strobe = saw_strobe | osd_strobe;
    step(1'b0, 1'b1, 8'h00);
    saw_strobe = saw_strobe | osd_strobe;
    step(1'b0, 1'b1, 8'h01);
    saw_strobe = saw_strobe | osd_strobe;
    total_cnt++; if (cfg_pending !== 1'b0) $display("FAIL ab_pending: got %0d expected 0", cfg_pending); else pass_cnt++;
    total_cnt++; if (saw_strobe !== 1'b0 || osd_start !== 1'b0) $display("FAIL ab_osd: got strobe %0d start %0d expected 0 0", saw_strobe, osd_start); else pass_cnt++;
    vs_in_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (system_volume !== 2'd3) $display("FAIL ab_volume: got %0d expected 3", system_volume); else pass_cnt++;
    vs_in_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset_n    = 1'b0;
    mcu_start  = 1'b0;
    mcu_strobe = 1'b0;
    mcu_data   = 8'h00;
    vs_in_n    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_osd();
    test_shadow_write();
    test_collision();
    test_mid_reset();
    test_read_wrap();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
